mdu_riscv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set for the RISC-V core. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake, computes the result over XLEN cycles with a shift-add multiplier and a restoring divider, and presents the result with output backpressure. Divide-by-zero and signed overflow are detected at issue and finish on a one-cycle fast path.

---
 rtl/mdu_riscv.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_riscv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_riscv.sv
// mdu_riscv: iterative RV32M/RV64M multiply/divide unit.
// One operation at a time: shift-add multiply or restoring divide on operand
// magnitudes over XLEN cycles, sign-corrected at the end. Divide-by-zero and
// signed divide overflow are resolved at issue and complete in one cycle.
module mdu_riscv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    // Multiply: {partial high, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    // ---------------- issue-time decode ----------------
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            neg_issue;
    logic            div_by_zero, div_ovf, fast_path;
    logic [XLEN-1:0] fast_result;

    // Operand signedness, magnitudes, result sign and fast-path detection.
    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed && a_i[XLEN-1];
        b_neg    = b_signed && b_i[XLEN-1];
        a_mag    = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag    = b_neg ? (~b_i + 1'b1) : b_i;
        // Remainders follow the dividend's sign; everything else is sign xor.
        if (op_i[2] && op_i[1]) begin
            neg_issue = a_neg;
        end else begin
            neg_issue = a_neg ^ b_neg;
        end
        div_by_zero = op_i[2] && (b_i == '0);
        // Signed overflow only exists for DIV/REM (op_i[0] = 0 among divides).
        div_ovf     = op_i[2] && !op_i[0] && (a_i == MOST_NEG) && (b_i == ALL_ONES);
        fast_path   = div_by_zero || div_ovf;
        if (div_by_zero) begin
            fast_result = op_i[1] ? a_i : ALL_ONES;
        end else begin
            fast_result = op_i[1] ? '0 : a_i;
        end
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff, div_rem;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step;

    // Shift-add multiply step and restoring divide step on the accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_mag_q});
        // When subtracting, the true difference is below b and fits in XLEN bits.
        div_diff  = div_shift[XLEN-1:0] - b_mag_q;
        div_rem   = div_ge ? div_diff : div_shift[XLEN-1:0];
        div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
        step      = op_q[2] ? div_next : mul_next;
    end

    // ---------------- final sign correction ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, final_res;

    // Negate the magnitude result if needed and select the requested half/part.
    always_comb begin
        prod_fix  = neg_q ? (~step + 1'b1) : step;
        mul_res   = (op_q[1:0] == OP_MUL[1:0]) ? prod_fix[XLEN-1:0]
                                               : prod_fix[2*XLEN-1:XLEN];
        div_sel   = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        div_res   = neg_q ? (~div_sel + 1'b1) : div_sel;
        final_res = op_q[2] ? div_res : mul_res;
    end

    // ---------------- control FSM ----------------
    // Next-state and datapath-load decisions for IDLE/CALC/DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                // kill_i wins over a new request.
                if (!kill_i && valid_i) begin
                    op_d    = op_i;
                    b_mag_d = b_mag;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    neg_d   = neg_issue;
                    cnt_d   = '0;
                    if (fast_path) begin
                        result_d = fast_result;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    acc_d = step;
                    if (cnt_q == CNT_LAST) begin
                        result_d = final_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (kill_i || ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE) && !rst_i;
    assign busy_o   = (state_q != S_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_riscv.sv
// Directed testbench for mdu_riscv: a 32-bit and an 8-bit instance.
module tb_mdu_riscv;

    logic        clk;
    logic        rst;

    logic        valid_i, ready_o, kill_i, valid_o, ready_i, busy_o;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, result_o;

    logic        valid8_i, ready8_o, kill8_i, valid8_o, ready8_i, busy8_o;
    logic [2:0]  op8_i;
    logic [7:0]  a8_i, b8_i, result8_o;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_riscv #(.XLEN(32)) u32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .busy_o(busy_o)
    );

    mdu_riscv #(.XLEN(8)) u8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid8_i), .ready_o(ready8_o),
        .op_i(op8_i), .a_i(a8_i), .b_i(b8_i), .kill_i(kill8_i),
        .valid_o(valid8_o), .ready_i(ready8_i), .result_o(result8_o), .busy_o(busy8_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue32(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check({tag, " ready"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Counts negedges until valid_o, starting at the current negedge.
    task automatic finish32(input string tag, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        while (!valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, 64'(result_o), 64'(exp));
    endtask

    task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        issue32(tag, op, a, b);
        finish32(tag, exp, exp_lat);
    endtask

    task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " ready"}, 64'(ready8_o), 64'd1);
        valid8_i = 1'b1; op8_i = op; a8_i = a; b8_i = b;
        @(negedge clk);
        valid8_i = 1'b0;
        lat = 0;
        while (!valid8_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " lat"}, 64'(lat), 64'(exp_lat));
        check({tag, " res"}, 64'(result8_o), 64'(exp));
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1; op_i = '0; a_i = '0; b_i = '0;
        valid8_i = 1'b0; kill8_i = 1'b0; ready8_i = 1'b1; op8_i = '0; a8_i = '0; b8_i = '0;
        repeat (3) @(negedge clk);
        check("rst ready", 64'(ready_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst valid", 64'(valid_o), 64'd0);
        check("rst result", 64'(result_o), 64'd0);
        check("rst ready8", 64'(ready8_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post rst ready", 64'(ready_o), 64'd1);

        // Multiply
        run32("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run32("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
        run32("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run32("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        // Divide
        run32("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run32("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run32("DIVU", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32);
        run32("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 32);
        run32("DIV pos/neg", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32);
        // Fast path
        run32("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run32("REM by 0", 3'd6, 32'd5, 32'd0, 32'd5, 0);
        run32("DIV by 0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run32("REMU by 0", 3'd7, 32'd9, 32'd0, 32'd9, 0);
        run32("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run32("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // valid_i pulses during CALC are ignored
        issue32("busy ign", 3'd5, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        valid_i = 1'b1; op_i = 3'd0; a_i = 32'd1; b_i = 32'd1;
        check("busy ign ready", 64'(ready_o), 64'd0);
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        finish32("busy ign", 32'd14, 28);
        @(negedge clk);
        check("busy ign idle", 64'(busy_o), 64'd0);

        // Backpressure
        ready_i = 1'b0;
        issue32("bp", 3'd0, 32'd6, 32'd7);
        finish32("bp", 32'd42, 32);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                valid_i = 1'b1; op_i = 3'd5; a_i = 32'd1; b_i = 32'd0;
            end
            if (i == 4) valid_i = 1'b0;
            check("bp valid", 64'(valid_o), 64'd1);
            check("bp result", 64'(result_o), 64'd42);
            check("bp ready", 64'(ready_o), 64'd0);
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("bp release ready", 64'(ready_o), 64'd1);
        check("bp release valid", 64'(valid_o), 64'd0);
        check("bp release result", 64'(result_o), 64'd42);

        // kill_i in CALC cycle 10
        issue32("kill", 3'd0, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        check("kill busy before", 64'(busy_o), 64'd1);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill busy", 64'(busy_o), 64'd0);
        check("kill ready", 64'(ready_o), 64'd1);
        check("kill valid", 64'(valid_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen = 1;
        end
        check("kill no valid", 64'(seen), 64'd0);

        // kill_i in IDLE has priority over valid_i
        @(negedge clk);
        kill_i = 1'b1; valid_i = 1'b1; op_i = 3'd5; a_i = 32'd1; b_i = 32'd0;
        @(negedge clk);
        kill_i = 1'b0; valid_i = 1'b0;
        check("kill idle busy", 64'(busy_o), 64'd0);
        check("kill idle valid", 64'(valid_o), 64'd0);

        // Reset in CALC cycle 5 (result_o still holds 42)
        issue32("rst mid", 3'd0, 32'd9, 32'd9);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid valid", 64'(valid_o), 64'd0);
        check("rst mid result", 64'(result_o), 64'd0);
        check("rst mid busy", 64'(busy_o), 64'd0);
        check("rst mid ready", 64'(ready_o), 64'd0);
        rst = 1'b0;
        run32("MUL 3*4", 3'd0, 32'd3, 32'd4, 32'd12, 32);

        // XLEN = 8 instance
        run8("X8 DIV ovf", 3'd4, 8'h80, 8'hFF, 8'h80, 0);
        run8("X8 MUL", 3'd0, 8'h0F, 8'h11, 8'hFF, 8);
        run8("X8 DIVU", 3'd5, 8'hC8, 8'h07, 8'h1C, 8);
        run8("X8 DIV", 3'd4, 8'h80, 8'h03, 8'hD6, 8);
        run8("X8 REM", 3'd6, 8'h80, 8'h03, 8'hFE, 8);
        run8("X8 MULH", 3'd1, 8'h80, 8'h80, 8'h40, 8);
        @(negedge clk);
        check("X8 idle", 64'(busy8_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
